// File: rtl/dot_product_responder.sv
// dot_product_responder: run/busy compute engine. Each run computes NUM_OUT
// signed dot products of a VEC_LEN-word input vector against consecutive weight
// rows and writes the saturated results to output SRAM, one per WRITE cycle.
// Optional feature macro: RESULT_RELU_EN (clamps negative results to zero).
module dot_product_responder #(
   parameter int          NUM_OUT  = 96,
   parameter int          VEC_LEN  = 9,
   parameter logic [11:0] IN_BASE  = 12'h0,
   parameter logic [11:0] W_BASE   = 12'h0,
   parameter logic [11:0] OUT_BASE = 12'h0,
   parameter int          SHIFT    = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        dut_run,
   output logic        dut_busy,
   output logic [11:0] dut_sram_read_address,
   input  logic [15:0] sram_dut_read_data,
   output logic [11:0] dut_wmem_read_address,
   input  logic [15:0] wmem_dut_read_data,
   output logic        dut_sram_write_enable,
   output logic [11:0] dut_sram_write_address,
   output logic [15:0] dut_sram_write_data
);

   localparam int AW = 32 + $clog2(VEC_LEN);
   localparam int IW = $clog2(VEC_LEN) + 1;
   localparam int KW = $clog2(NUM_OUT) + 1;
   localparam logic [IW-1:0] I_LAST = IW'(VEC_LEN - 1);
   localparam logic [KW-1:0] K_LAST = KW'(NUM_OUT - 1);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, WRITE} state_t;

   state_t                state_q, state_d;
   logic [IW-1:0]         i_q, i_d;
   logic [KW-1:0]         k_q, k_d;
   logic signed [AW-1:0]  acc_q, acc_d;
   logic [11:0]           row_q, row_d;
   logic [11:0]           raddr_q, raddr_d;
   logic [11:0]           waddr_q, waddr_d;
   logic                  busy_q, busy_d;
   logic                  we_q, we_d;
   logic [11:0]           wr_addr_q, wr_addr_d;
   logic [15:0]           wr_data_q, wr_data_d;

   logic signed [31:0]    prod;
   logic signed [AW-1:0]  acc_sum, acc_sh;
   logic [15:0]           sat, result;

   // Product of the pair whose data has just arrived, accumulated and scaled/saturated.
   always_comb begin
      prod    = $signed(sram_dut_read_data) * $signed(wmem_dut_read_data);
      acc_sum = acc_q + {{(AW-32){prod[31]}}, prod};
      acc_sh  = acc_sum >>> SHIFT;
      if (acc_sh[AW-1:15] == '0 || acc_sh[AW-1:15] == '1)
         sat = acc_sh[15:0];
      else
         sat = acc_sh[AW-1] ? 16'h8000 : 16'h7FFF;
`ifdef RESULT_RELU_EN
      result = sat[15] ? 16'h0000 : sat;
`else
      result = sat;
`endif
   end

   // Next-state logic; addresses are registered one cycle ahead of use.
   always_comb begin
      state_d   = state_q;
      i_d       = i_q;
      k_d       = k_q;
      acc_d     = acc_q;
      row_d     = row_q;
      raddr_d   = raddr_q;
      waddr_d   = waddr_q;
      we_d      = 1'b0;
      wr_addr_d = 12'h0;
      wr_data_d = 16'h0;
      case (state_q)
         IDLE: begin
            if (dut_run) begin
               state_d = FETCH;
               i_d     = '0;
               k_d     = '0;
               acc_d   = '0;
               row_d   = W_BASE;
               raddr_d = IN_BASE;
               waddr_d = W_BASE;
            end
         end
         FETCH: begin
            // data in the first FETCH cycle belongs to no issued pair
            if (i_q != '0) acc_d = acc_sum;
            if (i_q == I_LAST) begin
               state_d = DRAIN;
            end else begin
               i_d     = i_q + IW'(1);
               raddr_d = raddr_q + 12'd1;
               waddr_d = waddr_q + 12'd1;
            end
         end
         DRAIN: begin
            acc_d     = acc_sum;
            state_d   = WRITE;
            we_d      = 1'b1;
            wr_addr_d = OUT_BASE + 12'(k_q);
            wr_data_d = result;
         end
         default: begin
            if (k_q == K_LAST) begin
               state_d = IDLE;
            end else begin
               state_d = FETCH;
               k_d     = k_q + KW'(1);
               i_d     = '0;
               acc_d   = '0;
               row_d   = row_q + 12'(VEC_LEN);
               raddr_d = IN_BASE;
               waddr_d = row_q + 12'(VEC_LEN);
            end
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and registered outputs; reset drops any pending write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         i_q       <= '0;
         k_q       <= '0;
         acc_q     <= '0;
         row_q     <= '0;
         raddr_q   <= '0;
         waddr_q   <= '0;
         busy_q    <= 1'b0;
         we_q      <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         i_q       <= i_d;
         k_q       <= k_d;
         acc_q     <= acc_d;
         row_q     <= row_d;
         raddr_q   <= raddr_d;
         waddr_q   <= waddr_d;
         busy_q    <= busy_d;
         we_q      <= we_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign dut_busy               = busy_q;
   assign dut_sram_read_address  = raddr_q;
   assign dut_wmem_read_address  = waddr_q;
   assign dut_sram_write_enable  = we_q;
   assign dut_sram_write_address = wr_addr_q;
   assign dut_sram_write_data    = wr_data_q;

endmodule
